// File: rtl/dsp_pipe_reg.sv
// dsp_pipe_reg: clock-enabled WIDTH x DEPTH delay line with a selectable output tap,
// per-stage valid bits, a registered occupancy count and a valid-only flush.

module dsp_pipe_stage #(
  parameter int               WIDTH   = 18,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             FLUSH,
  input  logic             CE,
  input  logic [WIDTH-1:0] d_i,
  input  logic             vld_i,
  output logic [WIDTH-1:0] q_o,
  output logic             vld_o
);
  logic [WIDTH-1:0] q_q;
  logic             vld_q;

  // Flush only drops qualifiers; the data word stays where it was.
  always_ff @(posedge CLK) begin
    if (RST) begin
      q_q   <= RST_VAL;
      vld_q <= 1'b0;
    end else if (FLUSH) begin
      vld_q <= 1'b0;
    end else if (CE) begin
      q_q   <= d_i;
      vld_q <= vld_i;
    end
  end

  assign q_o   = q_q;
  assign vld_o = vld_q;
endmodule

module dsp_pipe_reg #(
  parameter int               WIDTH   = 18,
  parameter int               DEPTH   = 2,
  parameter bit               BYPASS  = 1'b0,
  parameter logic [WIDTH-1:0] RST_VAL = '0,
  localparam int              CW      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] in,
  input  logic             in_vld,
  input  logic [CW-1:0]    tap_sel,
  output logic [WIDTH-1:0] out,
  output logic             out_vld,
  output logic [CW-1:0]    fill_cnt,
  output logic             full
);

  if (BYPASS) begin : g_byp
    logic unused_byp;
    assign unused_byp = ^{CLK, RST, CE, FLUSH, tap_sel};
    assign out      = in;
    assign out_vld  = in_vld;
    assign fill_cnt = '0;
    assign full     = 1'b0;
  end else begin : g_pipe
    logic [DEPTH-1:0][WIDTH-1:0] stg_q;
    logic [DEPTH-1:0]            vld_q;
    logic [CW-1:0]               fill_q, fill_d;
    logic [CW-1:0]               tap_eff;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stg
      logic [WIDTH-1:0] d_k;
      logic             v_k;
      if (k == 0) begin : g_head
        assign d_k = in;
        assign v_k = in_vld;
      end else begin : g_body
        assign d_k = stg_q[k-1];
        assign v_k = vld_q[k-1];
      end
      dsp_pipe_stage #(.WIDTH(WIDTH), .RST_VAL(RST_VAL)) u_stg (
        .CLK   (CLK),
        .RST   (RST),
        .FLUSH (FLUSH),
        .CE    (CE),
        .d_i   (d_k),
        .vld_i (v_k),
        .q_o   (stg_q[k]),
        .vld_o (vld_q[k])
      );
    end

    // Tracks popcount(vld_q) incrementally: one in at the head, one out at the tail.
    always_comb begin
      fill_d = fill_q;
      case ({in_vld, vld_q[DEPTH-1]})
        2'b10:   if (fill_q != CW'(DEPTH)) fill_d = fill_q + 1'b1;
        2'b01:   if (fill_q != '0)         fill_d = fill_q - 1'b1;
        default: fill_d = fill_q;
      endcase
    end

    always_ff @(posedge CLK) begin
      if (RST || FLUSH) fill_q <= '0;
      else if (CE)      fill_q <= fill_d;
    end

    assign tap_eff = (tap_sel > CW'(DEPTH)) ? CW'(DEPTH) : tap_sel;

    always_comb begin
      out     = in;
      out_vld = in_vld;
      for (int t = 1; t <= DEPTH; t++) begin
        if (tap_eff == CW'(t)) begin
          out     = stg_q[t-1];
          out_vld = vld_q[t-1];
        end
      end
    end

    assign fill_cnt = fill_q;
    assign full     = (fill_q == CW'(DEPTH));
  end

endmodule
